// File: rtl/vga_cell_decoder.sv
// vga_cell_decoder: 3-stage raster-pixel to board-cell decoder with Connect Four board storage and colour lookup
module vga_cell_decoder #(
   parameter int GRID_LENGTH  = 2,
   parameter int BLOCK_LENGTH = 4,
   parameter int NUM_COLS     = 7,
   parameter int NUM_ROWS     = 6,
   parameter int COORD_W      = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [COORD_W-1:0] in_x,
   input  logic [COORD_W-1:0] in_y,
   input  logic               wr_en,
   input  logic [2:0]         wr_location,
   input  logic [2:0]         wr_height,
   input  logic               wr_player,
   input  logic               clear,
   output logic               out_valid,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y,
   output logic               out_hit,
   output logic [2:0]         out_location,
   output logic [2:0]         out_decoded_height,
   output logic [3:0]         out_pixel_count,
   output logic [2:0]         colour
);
   localparam int PITCH = GRID_LENGTH + BLOCK_LENGTH;
   localparam int NCELL = NUM_COLS * NUM_ROWS;
   localparam int X_END = GRID_LENGTH + NUM_COLS * PITCH;
   localparam int Y_END = GRID_LENGTH + NUM_ROWS * PITCH;

   // Compare against a constant ladder of block bases; returns {in_block, index[2:0], offset[1:0]}
   function automatic logic [5:0] f_decode(input logic [COORD_W-1:0] v, input int n);
      logic [5:0]         r;
      logic [COORD_W-1:0] base;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         base = COORD_W'(GRID_LENGTH + i * PITCH);
         if (i < n && v >= base && v < base + COORD_W'(BLOCK_LENGTH))
            r = {1'b1, 3'(i), 2'(v - base)};
      end
      return r;
   endfunction

   function automatic logic [5:0] f_idx(input logic [2:0] loc, input logic [2:0] h);
      return 6'(loc) * 6'(NUM_ROWS) + 6'(h);
   endfunction

   logic               r1_valid, r1_xreg;
   logic [COORD_W-1:0] r1_x, r1_y;
   logic [5:0]         r1_xd;
   logic               r2_valid, r2_xreg, r2_yreg;
   logic [COORD_W-1:0] r2_x, r2_y;
   logic [5:0]         r2_xd, r2_yd;
   logic [NCELL-1:0]   r_occ, r_own;
   logic [5:0]         w_xd, w_yd, w_rd_idx, w_wr_idx;
   logic               w_hit, w_region, w_wr_ok;
   logic [2:0]         w_colour;

   assign w_xd     = f_decode(in_x, NUM_COLS);
   assign w_yd     = f_decode(r1_y, NUM_ROWS);
   assign w_region = r2_xreg & r2_yreg;
   assign w_hit    = r2_xd[5] & r2_yd[5] & w_region;
   assign w_rd_idx = f_idx(r2_xd[4:2], r2_yd[4:2]);
   assign w_wr_idx = f_idx(wr_location, wr_height);
   assign w_wr_ok  = wr_en & (wr_location < 3'(NUM_COLS)) & (wr_height < 3'(NUM_ROWS));

   // Gap inside the board paints blue; empty cells and off-board pixels paint black
   always_comb
      w_colour = !w_region ? 3'b000 :
                 !w_hit ? 3'b001 :
                 r_occ[w_rd_idx] ? {1'b1, r_own[w_rd_idx], 1'b0} : 3'b000;

   // Stage 1: horizontal decode
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r1_valid <= 1'b0;
         r1_x     <= '0;
         r1_y     <= '0;
         r1_xd    <= '0;
         r1_xreg  <= 1'b0;
      end else begin
         r1_valid <= in_valid;
         r1_x     <= in_x;
         r1_y     <= in_y;
         r1_xd    <= w_xd;
         r1_xreg  <= in_x < COORD_W'(X_END);
      end

   // Stage 2: vertical decode
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r2_valid <= 1'b0;
         r2_x     <= '0;
         r2_y     <= '0;
         r2_xd    <= '0;
         r2_xreg  <= 1'b0;
         r2_yd    <= '0;
         r2_yreg  <= 1'b0;
      end else begin
         r2_valid <= r1_valid;
         r2_x     <= r1_x;
         r2_y     <= r1_y;
         r2_xd    <= r1_xd;
         r2_xreg  <= r1_xreg;
         r2_yd    <= w_yd;
         r2_yreg  <= r1_y < COORD_W'(Y_END);
      end

   // Stage 3: board lookup and registered outputs; decode fields are zeroed off-block
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         out_valid          <= 1'b0;
         out_x              <= '0;
         out_y              <= '0;
         out_hit            <= 1'b0;
         out_location       <= '0;
         out_decoded_height <= '0;
         out_pixel_count    <= '0;
         colour             <= '0;
      end else begin
         out_valid          <= r2_valid;
         out_x              <= r2_x;
         out_y              <= r2_y;
         out_hit            <= w_hit;
         out_location       <= w_hit ? r2_xd[4:2] : 3'd0;
         out_decoded_height <= w_hit ? r2_yd[4:2] : 3'd0;
         out_pixel_count    <= w_hit ? {r2_yd[1:0], r2_xd[1:0]} : 4'd0;
         colour             <= w_colour;
      end

   // Board state; clear beats a same-cycle write, and a write lands after the lookup that shares its cycle
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_occ <= '0;
         r_own <= '0;
      end else if (clear) begin
         r_occ <= '0;
         r_own <= '0;
      end else if (w_wr_ok) begin
         r_occ[w_wr_idx] <= 1'b1;
         r_own[w_wr_idx] <= wr_player;
      end
endmodule

// File: tb/tb_vga_cell_decoder.sv
// tb_vga_cell_decoder: directed checks of decode, colour, board writes, pipelining and reset
module tb_vga_cell_decoder;
   localparam int CW = 11;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [CW-1:0] in_x = '0, in_y = '0;
   logic          wr_en = 1'b0;
   logic [2:0]    wr_location = '0, wr_height = '0;
   logic          wr_player = 1'b0, clear = 1'b0;
   logic          out_valid, out_hit;
   logic [CW-1:0] out_x, out_y;
   logic [2:0]    out_location, out_decoded_height, colour;
   logic [3:0]    out_pixel_count;

   int n_vec = 0;
   int n_err = 0;
   bit m_occ [7][6];
   bit m_own [7][6];

   vga_cell_decoder dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
      .wr_en(wr_en), .wr_location(wr_location), .wr_height(wr_height),
      .wr_player(wr_player), .clear(clear), .out_valid(out_valid), .out_x(out_x),
      .out_y(out_y), .out_hit(out_hit), .out_location(out_location),
      .out_decoded_height(out_decoded_height), .out_pixel_count(out_pixel_count),
      .colour(colour)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear;
      for (int c = 0; c < 7; c++)
         for (int h = 0; h < 6; h++) begin
            m_occ[c][h] = 1'b0;
            m_own[c][h] = 1'b0;
         end
   endtask

   // Reference geometry by division/modulo
   task automatic model(input int x, input int y, output int hit, output int loc, output int ht,
                        output int pc, output int col);
      int cx, cy, ox, oy;
      bit xin, yin, rgn;
      cx  = (x - 2) / 6;
      ox  = (x - 2) % 6;
      cy  = (y - 2) / 6;
      oy  = (y - 2) % 6;
      xin = x >= 2 && x < 44 && ox < 4;
      yin = y >= 2 && y < 38 && oy < 4;
      rgn = x < 44 && y < 38;
      hit = (xin && yin) ? 1 : 0;
      loc = hit ? cx : 0;
      ht  = hit ? cy : 0;
      pc  = hit ? oy * 4 + ox : 0;
      col = !rgn ? 0 : !hit ? 1 : m_occ[cx][cy] ? 4 + 2 * int'(m_own[cx][cy]) : 0;
   endtask

   task automatic check_out(input int x, input int y);
      int hit, loc, ht, pc, col;
      model(x, y, hit, loc, ht, pc, col);
      chk($sformatf("valid(%0d,%0d)", x, y), 32'(out_valid), 1);
      chk($sformatf("x(%0d,%0d)", x, y), 32'(out_x), x);
      chk($sformatf("y(%0d,%0d)", x, y), 32'(out_y), y);
      chk($sformatf("hit(%0d,%0d)", x, y), 32'(out_hit), hit);
      chk($sformatf("loc(%0d,%0d)", x, y), 32'(out_location), loc);
      chk($sformatf("height(%0d,%0d)", x, y), 32'(out_decoded_height), ht);
      chk($sformatf("pixcnt(%0d,%0d)", x, y), 32'(out_pixel_count), pc);
      chk($sformatf("colour(%0d,%0d)", x, y), 32'(colour), col);
   endtask

   task automatic do_req(input int x, input int y);
      in_valid = 1'b1;
      in_x = CW'(x);
      in_y = CW'(y);
      tick;
      in_valid = 1'b0;
      tick;
      chk("latency_early", 32'(out_valid), 0);
      tick;
      check_out(x, y);
   endtask

   task automatic wr(input int loc, input int h, input bit p);
      wr_en = 1'b1;
      wr_location = 3'(loc);
      wr_height = 3'(h);
      wr_player = p;
      tick;
      wr_en = 1'b0;
      if (loc < 7 && h < 6) begin
         m_occ[loc][h] = 1'b1;
         m_own[loc][h] = p;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 0);
      chk({tag, "_hit"}, 32'(out_hit), 0);
      chk({tag, "_colour"}, 32'(colour), 0);
      chk({tag, "_x"}, 32'(out_x), 0);
      chk({tag, "_loc"}, 32'(out_location), 0);
      chk({tag, "_pixcnt"}, 32'(out_pixel_count), 0);
   endtask

   initial begin
      bit [7:0] mask;
      model_clear();
      #12;
      chk_zero("reset");
      #2 reset = 1'b0;
      tick;
      // Basic decode and colours
      do_req(2, 2);
      wr(3, 2, 1'b1);
      do_req(21, 16);
      do_req(43, 37);
      do_req(44, 10);
      do_req(7, 2);
      do_req(5, 5);
      do_req(0, 0);
      // Out-of-range writes must not alias onto real cells
      wr(7, 0, 1'b1);
      wr(0, 6, 1'b1);
      wr(6, 6, 1'b1);
      do_req(8, 2);
      do_req(41, 35);
      // Clear wins over a same-cycle write
      clear = 1'b1;
      wr(4, 1, 1'b1);
      clear = 1'b0;
      model_clear();
      do_req(21, 16);
      do_req(26, 8);
      // Lookup and write to the same cell in one cycle: old value, then new
      in_valid = 1'b1;
      in_x = CW'(2);
      in_y = CW'(2);
      tick;
      tick;
      in_valid = 1'b0;
      wr_en = 1'b1;
      wr_location = 3'd0;
      wr_height = 3'd0;
      wr_player = 1'b0;
      tick;
      wr_en = 1'b0;
      check_out(2, 2);
      m_occ[0][0] = 1'b1;
      m_own[0][0] = 1'b0;
      tick;
      check_out(2, 2);
      // Fill row 0 and stream a full scanline
      wr(2, 0, 1'b1);
      wr(5, 0, 1'b0);
      wr(5, 0, 1'b1);
      wr(6, 0, 1'b0);
      for (int i = 0; i < 48; i++) begin
         in_valid = i < 46;
         in_x = CW'(i);
         in_y = CW'(3);
         tick;
         if (i >= 2) check_out(i - 2, 3);
      end
      // Bubble pattern must reappear unchanged at the output
      mask = 8'b0100_1101;
      for (int i = 0; i < 10; i++) begin
         in_valid = i < 8 ? mask[i] : 1'b0;
         in_x = CW'(100 + i);
         in_y = CW'(3);
         tick;
         if (i >= 2) begin
            chk($sformatf("bubble_valid%0d", i - 2), 32'(out_valid), 32'(mask[i-2]));
            if (mask[i-2]) chk($sformatf("bubble_x%0d", i - 2), 32'(out_x), 100 + i - 2);
         end
      end
      // Asynchronous reset with requests in flight
      in_valid = 1'b1;
      in_x = CW'(33);
      in_y = CW'(3);
      tick;
      in_x = CW'(2);
      tick;
      in_x = CW'(14);
      tick;
      in_valid = 1'b0;
      chk("pre_reset_valid", 32'(out_valid), 1);
      chk("pre_reset_colour", 32'(colour), 6);
      #2 reset = 1'b1;
      #1;
      chk_zero("async_reset");
      tick;
      tick;
      #3 reset = 1'b0;
      model_clear();
      for (int i = 0; i < 4; i++) begin
         tick;
         chk($sformatf("no_stale%0d", i), 32'(out_valid), 0);
      end
      do_req(33, 3);
      do_req(2, 3);
      do_req(21, 16);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
